// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and the
// default starvation limit.
package dmem_arb_pkg;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic {
    ST_CPU    = 1'b0,
    ST_PERIPH = 1'b1
  } owner_e;
endpackage

// File: rtl/dmem_arbiter.sv
// Single-port RAM arbiter between a CPU and a peripheral. The CPU has priority
// until a peripheral request has waited STARVE_LIMIT cycles; then the CPU is stalled.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              anti_reset,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [15:0]       starve_events
);
  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  owner_e              owner_q, owner_d;
  logic                rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0]    wait_cnt;
  logic [15:0]         starve_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                p_own, forced, cpu_rd_ret;

  // State register: owner and read-ness of the access issued this cycle
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      owner_q      <= ST_CPU;
      rd_pending_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  // Next state: decide who owns this cycle's RAM access
  always_comb begin
    forced       = p_req & cpu_en & (wait_cnt == LIMIT);
    p_own        = p_req & (~cpu_en | forced);
    owner_d      = p_own ? ST_PERIPH : ST_CPU;
    rd_pending_d = p_own ? ~p_we : (cpu_en & ~cpu_we);
  end

  // Outputs: RAM mux follows the owner; read returns follow the registered owner
  always_comb begin
    p_gnt      = p_own;
    cpu_stall  = forced;
    ram_addr   = p_own ? p_addr  : cpu_addr;
    ram_din    = p_own ? p_wdata : cpu_wdata;
    ram_wen    = p_own ? p_we    : (cpu_we & cpu_en);
    p_rvalid   = (owner_q == ST_PERIPH) & rd_pending_q;
    p_rdata    = p_rvalid ? ram_dout : '0;
    cpu_ret_sel: begin
      cpu_rd_ret = (owner_q == ST_CPU) & rd_pending_q;
      cpu_rdata  = cpu_rd_ret ? ram_dout : cpu_rdata_q;
    end
    starve_events = starve_q;
  end

  // Wait counter, starvation statistics and the held CPU read value
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      wait_cnt    <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (!p_req || p_own)     wait_cnt <= '0;
      else if (wait_cnt < LIMIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (forced && starve_q != 16'hFFFF) starve_q <= starve_q + 16'd1;
      if (cpu_rd_ret) cpu_rdata_q <= ram_dout;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle RAM and a
// scoreboard of expected peripheral read data.
module tb_dmem_arbiter;
  logic        clock = 1'b0;
  logic        anti_reset;
  logic        cpu_en, cpu_we, p_req, p_we;
  logic [11:0] cpu_addr, p_addr;
  logic [31:0] cpu_wdata, p_wdata;
  logic [31:0] cpu_rdata, p_rdata, ram_din, ram_dout;
  logic        cpu_stall, p_gnt, p_rvalid, ram_wen;
  logic [11:0] ram_addr;
  logic [15:0] starve_events;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [4096];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  dmem_arbiter dut (
    .clock(clock), .anti_reset(anti_reset),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .starve_events(starve_events)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic ce, input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                     input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd);
    cpu_en = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    p_req  = pr; p_we   = pw; p_addr   = pa; p_wdata   = pd;
    #1;
  endtask

  // Compare a returned peripheral read against the oldest expected value
  task automatic pop_rd(input string tag);
    logic [31:0] e;
    chk({tag, "_rvalid"}, 32'(p_rvalid), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
    chk({tag, "_rdata"}, p_rdata, e);
  endtask

  // CPU read of 0x030 contending with a peripheral read of 0x010 until forced
  task automatic starve_round(input string tag);
    drv(1, 0, 12'h030, 0, 1, 0, 12'h010, 0);
    repeat (8) tick();
    chk({tag, "_gnt"}, 32'(p_gnt), 32'd1);
    chk({tag, "_stall"}, 32'(cpu_stall), 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    tick();
    drv(1, 0, 12'h030, 0, 0, 0, 12'h000, 0);
    pop_rd(tag);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    anti_reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rvalid", 32'(p_rvalid), 0);
    chk("rst_prdata", p_rdata, 0);
    chk("rst_cpurdata", cpu_rdata, 0);
    chk("rst_starve", 32'(starve_events), 0);
    chk("rst_gnt", 32'(p_gnt), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_wen", 32'(ram_wen), 0);
    @(negedge clock) anti_reset = 1'b1;

    // Preload RAM through the CPU write path
    tick(); drv(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("cpuwr_wen", 32'(ram_wen), 1);
    chk("cpuwr_din", ram_din, 32'hDEADBEEF);
    chk("cpuwr_gnt", 32'(p_gnt), 0);
    tick(); drv(1, 1, 12'h030, 32'hA5A5A5A5, 0, 0, 0, 0);
    tick(); drv(0, 1, 12'h040, 32'hFFFFFFFF, 0, 0, 0, 0);
    chk("cpuwe_noen_wen", 32'(ram_wen), 0);
    chk("cpuwe_noen_addr", 32'(ram_addr), 32'h040);

    // Idle-cycle peripheral read
    tick(); drv(0, 0, 0, 0, 1, 0, 12'h010, 0);
    chk("prd_gnt", 32'(p_gnt), 1);
    chk("prd_stall", 32'(cpu_stall), 0);
    chk("prd_addr", 32'(ram_addr), 32'h010);
    chk("prd_wen", 32'(ram_wen), 0);
    exp_q.push_back(32'hDEADBEEF);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0);
    pop_rd("prd");

    // Idle-cycle peripheral write, then read it back
    tick(); drv(0, 0, 0, 0, 1, 1, 12'h020, 32'h12345678);
    chk("pwr_gnt", 32'(p_gnt), 1);
    chk("pwr_wen", 32'(ram_wen), 1);
    chk("pwr_addr", 32'(ram_addr), 32'h020);
    chk("pwr_din", ram_din, 32'h12345678);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pwr_norvalid", 32'(p_rvalid), 0);
    tick(); drv(0, 0, 0, 0, 1, 0, 12'h020, 0);
    exp_q.push_back(32'h12345678);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0);
    pop_rd("prb");

    // Contention: CPU wins 8 cycles, peripheral forced on the 9th
    tick(); drv(1, 0, 12'h030, 0, 1, 0, 12'h010, 0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("cont%0d_gnt", c), 32'(p_gnt), 0);
      chk($sformatf("cont%0d_stall", c), 32'(cpu_stall), 0);
      chk($sformatf("cont%0d_addr", c), 32'(ram_addr), 32'h030);
      if (c > 1) chk($sformatf("cont%0d_cpurd", c), cpu_rdata, 32'hA5A5A5A5);
      tick();
    end
    chk("force_gnt", 32'(p_gnt), 1);
    chk("force_stall", 32'(cpu_stall), 1);
    chk("force_addr", 32'(ram_addr), 32'h010);
    chk("force_cpurd", cpu_rdata, 32'hA5A5A5A5);
    exp_q.push_back(32'hDEADBEEF);
    tick(); drv(1, 0, 12'h030, 0, 0, 0, 0, 0);
    pop_rd("force");
    chk("after_cpurd_hold", cpu_rdata, 32'hA5A5A5A5);
    chk("after_starve", 32'(starve_events), 1);
    chk("after_gnt", 32'(p_gnt), 0);
    chk("after_stall", 32'(cpu_stall), 0);
    chk("after_addr", 32'(ram_addr), 32'h030);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_cpurd", cpu_rdata, 32'hA5A5A5A5);

    // Starvation counter saturation
    force dut.starve_q = 16'hFFFE;
    #1 release dut.starve_q;
    starve_round("sat1");
    chk("sat1_cnt", 32'(starve_events), 32'hFFFF);
    starve_round("sat2");
    chk("sat2_cnt", 32'(starve_events), 32'hFFFF);

    // Reset while a peripheral read is in flight
    tick(); drv(0, 0, 0, 0, 1, 0, 12'h010, 0);
    chk("rstmid_gnt", 32'(p_gnt), 1);
    #2 anti_reset = 1'b0;
    tick();
    chk("rstmid_rvalid", 32'(p_rvalid), 0);
    chk("rstmid_prdata", p_rdata, 0);
    chk("rstmid_cpurd", cpu_rdata, 0);
    chk("rstmid_starve", 32'(starve_events), 0);
    chk("rstmid_comb_gnt", 32'(p_gnt), 1);
    @(negedge clock) anti_reset = 1'b1;
    drv(1, 0, 12'h030, 0, 1, 0, 12'h010, 0);
    chk("rstmid_cpu_wins", 32'(p_gnt), 0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstmid_norvalid", 32'(p_rvalid), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
